lcd_byte_sched: RTL and testbench
=================================

LCD_BYTE_SCHED -- requirements
Module: lcd_byte_sched

Interface
REQ-001 Parameter FREQ, default 50000000, system clock frequency in Hz used to derive all delay constants.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 init_done  input  1  level; high once the LCD power-on init sequence has completed; no grants while low.
REQ-005 a_valid  input  1  requester A has a byte pending; held high until a_ready.
REQ-006 a_data  input  8  requester A byte (command or character).
REQ-007 a_rs  input  1  requester A register select: 0 command, 1 data.
REQ-008 a_ready  output  1  one-cycle pulse; requester A byte accepted this cycle.
REQ-009 b_valid, b_data[7:0], b_rs, b_ready  same directions, widths and meaning as REQ-005..008, for requester B.
REQ-010 xfer_start  output  1  one-cycle pulse; instructs the nibble transfer engine to send one nibble.
REQ-011 xfer_nibble  output  4  nibble presented to the transfer engine; stable from xfer_start until xfer_done.
REQ-012 xfer_delay  output  21  post-nibble delay in clock cycles for the transfer engine.
REQ-013 xfer_read_busy  output  1  1 = transfer engine polls busy flag after this nibble.
REQ-014 xfer_done  input  1  one-cycle pulse from the transfer engine; current nibble complete.
REQ-015 LCD_RS  output  1  register select driven to the panel for the byte in flight.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 grant_b  output  1  0 = byte in flight is from A, 1 = from B; valid while busy.

Function
REQ-018 Delay constants: T1US = FREQ/1000000; T10US = 10*T1US; T53US = 53*T1US; T3MS = 3000*T1US; all truncated to 21 bits.
REQ-019 States: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
REQ-020 IDLE: if init_done=1 and any valid high, grant one requester, pulse its ready combinationally this cycle, latch data/rs/grant at the edge, go to SEND_HI.
REQ-021 Arbitration round-robin: on simultaneous a_valid and b_valid, grant the requester not granted last; pointer after reset favours A.
REQ-022 Single requester valid: grant it regardless of pointer; pointer updates to the granted requester.
REQ-023 SEND_HI (exactly one cycle): xfer_start=1, xfer_nibble=data[7:4], xfer_delay=T10US, xfer_read_busy=0, LCD_RS=latched rs; next state WAIT_HI.
REQ-024 WAIT_HI: hold nibble/delay/read_busy/LCD_RS; on xfer_done go to SEND_LO.
REQ-025 SEND_LO (one cycle): xfer_start=1, xfer_nibble=data[3:0], xfer_read_busy=1, xfer_delay=T3MS if rs=0 and data in {0x01,0x02,0x03}, else T53US; next WAIT_LO.
REQ-026 WAIT_LO: on xfer_done go to IDLE; a new grant is possible in the first IDLE cycle (no extra gap).
REQ-027 xfer_done is ignored in IDLE, SEND_HI and SEND_LO.
REQ-028 a_valid/b_valid/data changes after acceptance do not affect the byte in flight.
REQ-029 Dropping init_done mid-byte does not abort the byte; it only blocks the next grant.
REQ-030 Never both a_ready and b_ready in one cycle; at most one ready pulse per byte.
REQ-031 Outputs xfer_*, LCD_RS, busy, grant_b are registered; only a_ready/b_ready are combinational.

Reset
REQ-032 RESET asserted: state IDLE, xfer_start=0, xfer_nibble=0, xfer_delay=0, xfer_read_busy=0, LCD_RS=0, busy=0, grant_b=0, a_ready=b_ready=0, RR pointer favours A.
REQ-033 RESET mid-byte: byte in flight discarded, no further xfer_start, requester not re-acked until re-granted after release.

Verification
REQ-034 init_done=0, a_valid=1 for 100 cycles -> no a_ready, no xfer_start; raise init_done -> a_ready same cycle.
REQ-035 A sends rs=1, 0x48 -> xfer_start with nibble 0x4, delay 500, rb=0; after xfer_done, nibble 0x8, delay 2650, rb=1, LCD_RS=1 throughout.
REQ-036 A sends rs=0, 0x01 -> low nibble 0x1 with xfer_delay=150000; same byte with rs=1 -> 2650.
REQ-037 a_valid and b_valid held together for 4 bytes each -> grants A,B,A,B,...; no ready overlap.
REQ-038 xfer_done pulsed in IDLE and in SEND_HI -> no state advance; exactly two xfer_start per byte.
REQ-039 RESET asserted in WAIT_LO -> all outputs at reset values next sample; after release, pending a_valid granted with fresh high nibble.

Source files
------------

// File: rtl/lcd_byte_sched.sv
// Two-requester byte scheduler for a 4-bit LCD bus: arbitrates A/B round-robin and
// splits each granted byte into high/low nibble transfers with the matching post-delay.
module lcd_byte_sched #(
   parameter int FREQ = 50000000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        init_done,
   input  logic        a_valid,
   input  logic [7:0]  a_data,
   input  logic        a_rs,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [7:0]  b_data,
   input  logic        b_rs,
   output logic        b_ready,
   output logic        xfer_start,
   output logic [3:0]  xfer_nibble,
   output logic [20:0] xfer_delay,
   output logic        xfer_read_busy,
   input  logic        xfer_done,
   output logic        LCD_RS,
   output logic        busy,
   output logic        grant_b
);

   localparam int          T1US  = FREQ / 1000000;
   localparam logic [20:0] T10US = 21'(10 * T1US);
   localparam logic [20:0] T53US = 21'(53 * T1US);
   localparam logic [20:0] T3MS  = 21'(3000 * T1US);

   typedef enum logic [2:0] {IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO} state_t;

   state_t      state_q, state_d;
   logic [7:0]  data_q, data_d;
   logic        rs_q, rs_d;
   logic        grant_b_q, grant_b_d;
   logic        favour_b_q, favour_b_d;
   logic        start_q, start_d;
   logic [3:0]  nibble_q, nibble_d;
   logic [20:0] delay_q, delay_d;
   logic        rb_q, rb_d;
   logic        lcd_rs_q, lcd_rs_d;
   logic        busy_q, busy_d;
   logic        pick_a, pick_b, grant_ok, long_cmd;

   // B wins a tie only when the pointer favours it; a lone requester always wins.
   assign pick_a   = a_valid & (~b_valid | ~favour_b_q);
   assign pick_b   = b_valid & ~pick_a;
   assign grant_ok = (state_q == IDLE) & init_done & ~RESET;
   assign a_ready  = grant_ok & pick_a;
   assign b_ready  = grant_ok & pick_b;

   assign xfer_start     = start_q;
   assign xfer_nibble    = nibble_q;
   assign xfer_delay     = delay_q;
   assign xfer_read_busy = rb_q;
   assign LCD_RS         = lcd_rs_q;
   assign busy           = busy_q;
   assign grant_b        = grant_b_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         favour_b_q <= 1'b0;
         grant_b_q  <= 1'b0;
         start_q    <= 1'b0;
         nibble_q   <= 4'h0;
         delay_q    <= 21'd0;
         rb_q       <= 1'b0;
         lcd_rs_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         favour_b_q <= favour_b_d;
         grant_b_q  <= grant_b_d;
         start_q    <= start_d;
         nibble_q   <= nibble_d;
         delay_q    <= delay_d;
         rb_q       <= rb_d;
         lcd_rs_q   <= lcd_rs_d;
         busy_q     <= busy_d;
      end
   end

   always_ff @(posedge CLK) begin
      data_q <= data_d;
      rs_q   <= rs_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (a_ready | b_ready) state_d = SEND_HI;
         SEND_HI: state_d = WAIT_HI;
         WAIT_HI: if (xfer_done) state_d = SEND_LO;
         SEND_LO: state_d = WAIT_LO;
         WAIT_LO: if (xfer_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed for the state being entered so they appear registered.
   always_comb begin
      data_d     = data_q;
      rs_d       = rs_q;
      grant_b_d  = grant_b_q;
      favour_b_d = favour_b_q;
      if (a_ready) begin
         data_d     = a_data;
         rs_d       = a_rs;
         grant_b_d  = 1'b0;
         favour_b_d = 1'b1;
      end else if (b_ready) begin
         data_d     = b_data;
         rs_d       = b_rs;
         grant_b_d  = 1'b1;
         favour_b_d = 1'b0;
      end
      long_cmd = ~rs_d & ((data_d == 8'h01) | (data_d == 8'h02) | (data_d == 8'h03));
      start_d  = 1'b0;
      nibble_d = nibble_q;
      delay_d  = delay_q;
      rb_d     = rb_q;
      lcd_rs_d = lcd_rs_q;
      busy_d   = (state_d != IDLE);
      case (state_d)
         SEND_HI: begin
            start_d  = 1'b1;
            nibble_d = data_d[7:4];
            delay_d  = T10US;
            rb_d     = 1'b0;
            lcd_rs_d = rs_d;
         end
         SEND_LO: begin
            start_d  = 1'b1;
            nibble_d = data_d[3:0];
            delay_d  = long_cmd ? T3MS : T53US;
            rb_d     = 1'b1;
            lcd_rs_d = rs_d;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_lcd_byte_sched.sv
// Directed bench for lcd_byte_sched at the default 50 MHz clock.
module tb_lcd_byte_sched;

   localparam int T10 = 500;
   localparam int T53 = 2650;
   localparam int T3M = 150000;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        init_done = 1'b0;
   logic        a_valid = 1'b0, a_rs = 1'b0, b_valid = 1'b0, b_rs = 1'b0;
   logic [7:0]  a_data = 8'h00, b_data = 8'h00;
   logic        a_ready, b_ready;
   logic        xfer_start, xfer_read_busy, LCD_RS, busy, grant_b;
   logic [3:0]  xfer_nibble;
   logic [20:0] xfer_delay;
   logic        xfer_done = 1'b0;

   int compared = 0;
   int mismatched = 0;

   lcd_byte_sched dut (
      .CLK(CLK), .RESET(RESET), .init_done(init_done),
      .a_valid(a_valid), .a_data(a_data), .a_rs(a_rs), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_rs(b_rs), .b_ready(b_ready),
      .xfer_start(xfer_start), .xfer_nibble(xfer_nibble), .xfer_delay(xfer_delay),
      .xfer_read_busy(xfer_read_busy), .xfer_done(xfer_done),
      .LCD_RS(LCD_RS), .busy(busy), .grant_b(grant_b)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts in the grant cycle; ends in the first IDLE cycle after the byte.
   task automatic do_byte(input string tag, input bit is_b, input logic [7:0] d,
                          input logic r, input logic [20:0] lo_dly, input bit drop);
      int starts;
      starts = 0;
      #1;
      chk({tag, ".ready"}, {30'd0, a_ready, b_ready}, is_b ? 32'd1 : 32'd2);
      cyc();
      starts += int'(xfer_start);
      if (drop) begin
         a_valid = 1'b0; b_valid = 1'b0; a_data = 8'hFF; b_data = 8'hFF;
      end
      chk({tag, ".hi"}, {23'd0, xfer_start, xfer_nibble, xfer_read_busy, LCD_RS, busy, grant_b},
          {23'd0, 1'b1, d[7:4], 1'b0, r, 1'b1, is_b});
      chk({tag, ".hi_dly"}, {11'd0, xfer_delay}, T10);
      cyc();
      starts += int'(xfer_start);
      chk({tag, ".wait_hi"}, {29'd0, xfer_start, a_ready, b_ready}, 32'd0);
      xfer_done = 1'b1;
      cyc();
      xfer_done = 1'b0;
      starts += int'(xfer_start);
      chk({tag, ".lo"}, {23'd0, xfer_start, xfer_nibble, xfer_read_busy, LCD_RS, busy, grant_b},
          {23'd0, 1'b1, d[3:0], 1'b1, r, 1'b1, is_b});
      chk({tag, ".lo_dly"}, {11'd0, xfer_delay}, {11'd0, lo_dly});
      cyc();
      starts += int'(xfer_start);
      xfer_done = 1'b1;
      cyc();
      xfer_done = 1'b0;
      starts += int'(xfer_start);
      chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
      chk({tag, ".starts"}, starts, 32'd2);
   endtask

   initial begin
      int rdy_cnt, st_cnt;
      // Reset state, with a request pending to show ready is held off.
      init_done = 1'b1; a_valid = 1'b1;
      cyc(); cyc();
      chk("rst.outs", {22'd0, xfer_start, xfer_nibble, xfer_read_busy, LCD_RS, busy, grant_b, a_ready, b_ready}, 32'd0);
      chk("rst.dly", {11'd0, xfer_delay}, 32'd0);
      init_done = 1'b0;
      RESET = 1'b0;

      // No grants while init is incomplete.
      a_data = 8'h48; a_rs = 1'b1;
      rdy_cnt = 0; st_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         rdy_cnt += int'(a_ready);
         st_cnt  += int'(xfer_start);
      end
      chk("noinit.ready", rdy_cnt, 32'd0);
      chk("noinit.start", st_cnt, 32'd0);
      init_done = 1'b1;
      do_byte("a48", 1'b0, 8'h48, 1'b1, 21'(T53), 1'b1);

      // Clear/home commands take the long delay only as commands.
      a_valid = 1'b1; a_data = 8'h01; a_rs = 1'b0;
      do_byte("cmd01", 1'b0, 8'h01, 1'b0, 21'(T3M), 1'b1);
      a_valid = 1'b1; a_data = 8'h01; a_rs = 1'b1;
      do_byte("dat01", 1'b0, 8'h01, 1'b1, 21'(T53), 1'b1);
      a_valid = 1'b1; a_data = 8'h03; a_rs = 1'b0;
      do_byte("cmd03", 1'b0, 8'h03, 1'b0, 21'(T3M), 1'b1);
      a_valid = 1'b1; a_data = 8'h04; a_rs = 1'b0;
      do_byte("cmd04", 1'b0, 8'h04, 1'b0, 21'(T53), 1'b1);

      // Round-robin from a fresh pointer.
      RESET = 1'b1;
      cyc();
      RESET = 1'b0;
      a_valid = 1'b1; a_data = 8'h41; a_rs = 1'b1;
      b_valid = 1'b1; b_data = 8'h62; b_rs = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_byte($sformatf("rr%0d", i), bit'(i % 2), (i % 2 == 1) ? 8'h62 : 8'h41, 1'b1, 21'(T53), 1'b0);
      end
      a_valid = 1'b0; b_valid = 1'b0;

      // xfer_done outside the wait states must not advance the FSM.
      xfer_done = 1'b1;
      cyc();
      xfer_done = 1'b0;
      chk("done_idle", {30'd0, busy, xfer_start}, 32'd0);
      a_valid = 1'b1; a_data = 8'h35; a_rs = 1'b1;
      #1;
      chk("d38.ready", {31'd0, a_ready}, 32'd1);
      cyc();
      a_valid = 1'b0;
      xfer_done = 1'b1;
      chk("d38.hi", {27'd0, xfer_start, xfer_nibble}, 32'h13);
      cyc();
      xfer_done = 1'b0;
      chk("d38.wait1", {26'd0, busy, xfer_start, xfer_nibble}, 32'h23);
      cyc();
      chk("d38.wait2", {26'd0, busy, xfer_start, xfer_nibble}, 32'h23);
      xfer_done = 1'b1;
      cyc();
      xfer_done = 1'b0;
      chk("d38.lo", {27'd0, xfer_start, xfer_nibble}, 32'h15);
      cyc();
      xfer_done = 1'b1;
      cyc();
      xfer_done = 1'b0;

      // Reset during WAIT_LO discards the byte; pending request regranted afterwards.
      a_valid = 1'b1; a_data = 8'hC7; a_rs = 1'b0;
      #1;
      chk("r39.ready", {31'd0, a_ready}, 32'd1);
      cyc();
      a_valid = 1'b0;
      chk("r39.hi", {28'd0, xfer_nibble}, 32'hC);
      cyc();
      xfer_done = 1'b1;
      cyc();
      xfer_done = 1'b0;
      chk("r39.lo_dly", {11'd0, xfer_delay}, T53);
      cyc();
      chk("r39.wait_lo", {30'd0, busy, xfer_start}, 32'd2);
      a_valid = 1'b1; a_data = 8'h5A; a_rs = 1'b1;
      RESET = 1'b1;
      #1;
      chk("r39.rst", {22'd0, xfer_start, xfer_nibble, xfer_read_busy, LCD_RS, busy, grant_b, a_ready, b_ready}, 32'd0);
      chk("r39.rst_dly", {11'd0, xfer_delay}, 32'd0);
      cyc();
      chk("r39.rst_hold", {30'd0, busy, xfer_start}, 32'd0);
      RESET = 1'b0;
      #1;
      chk("r39.regrant", {30'd0, a_ready, b_ready}, 32'd2);
      cyc();
      a_valid = 1'b0;
      chk("r39.fresh", {25'd0, xfer_start, xfer_nibble, LCD_RS, grant_b}, {25'd0, 1'b1, 4'h5, 1'b1, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
